countdown_1k: RTL and testbench

Loadable decimal-range countdown timer, the counting-down counterpart to the free-running 0..999 up-counter. It accepts a start value 0..999 through a valid/ready load handshake and decrements once per qualified tick. It reports terminal count with a one-cycle `done` pulse. It sits beside the up-counter in the timing/sequencing logic and provides programmable delays and watchdog intervals.

---
 rtl/countdown_1k.sv | 93 +++++++++
 tb/tb_countdown_1k.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/countdown_1k.sv
// Loadable 0..999 countdown timer with one-cycle done pulse; periodic mode under COUNTDOWN_1K_AUTORELOAD_EN.
// Latency: q/busy valid one cycle after the accepting edge; done one cycle after the terminal tick.
// Backpressure: load_ready is high only in IDLE, so a load offered while running waits.
module countdown_1k (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       load_valid,
    output logic       load_ready,
    input  logic [9:0] load_val,
    input  logic       tick,
    input  logic       pause,
    input  logic       abort,
    output logic [9:0] q,
    output logic       busy,
    output logic       done
);

    localparam logic [9:0] MAX_VAL = 10'd999;

    typedef enum logic {IDLE, RUN} state_t;

    state_t     state, state_n;
    logic [9:0] q_n;
    logic       done_n;
    logic [9:0] load_clamped;

`ifdef COUNTDOWN_1K_AUTORELOAD_EN
    logic [9:0] reload, reload_n;
`endif

    assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;
    assign busy         = (state == RUN);
    assign load_ready   = (state == IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            q      <= '0;
            done   <= 1'b0;
`ifdef COUNTDOWN_1K_AUTORELOAD_EN
            reload <= '0;
`endif
        end else begin
            state  <= state_n;
            q      <= q_n;
            done   <= done_n;
`ifdef COUNTDOWN_1K_AUTORELOAD_EN
            reload <= reload_n;
`endif
        end
    end

    always_comb begin
        state_n  = state;
        q_n      = q;
        done_n   = 1'b0;
`ifdef COUNTDOWN_1K_AUTORELOAD_EN
        reload_n = reload;
`endif
        case (state)
            IDLE: begin
                if (load_valid) begin
                    q_n = load_clamped;
`ifdef COUNTDOWN_1K_AUTORELOAD_EN
                    reload_n = load_clamped;
`endif
                    // A zero load completes immediately rather than entering RUN.
                    if (load_clamped != 10'd0) state_n = RUN;
                    else                       done_n  = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                end else if (!pause && tick) begin
                    if (q > 10'd1) begin
                        q_n = q - 10'd1;
                    end else begin
                        done_n = 1'b1;
`ifdef COUNTDOWN_1K_AUTORELOAD_EN
                        q_n = reload;
`else
                        q_n     = 10'd0;
                        state_n = IDLE;
`endif
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: tb/tb_countdown_1k.sv
// Directed bench for countdown_1k; autoreload section is built when COUNTDOWN_1K_AUTORELOAD_EN is defined.
module tb_countdown_1k;

    logic       clk;
    logic       reset_n;
    logic       load_valid;
    logic       load_ready;
    logic [9:0] load_val;
    logic       tick;
    logic       pause;
    logic       abort;
    logic [9:0] q;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;

    countdown_1k dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_val   (load_val),
        .tick       (tick),
        .pause      (pause),
        .abort      (abort),
        .q          (q),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int eq, input int ebusy,
                           input int edone, input int erdy);
        chk({tag, ".q"},          int'(q),          eq);
        chk({tag, ".busy"},       int'(busy),       ebusy);
        chk({tag, ".done"},       int'(done),       edone);
        chk({tag, ".load_ready"}, int'(load_ready), erdy);
    endtask

    task automatic do_load(input logic [9:0] v);
        load_valid = 1'b1;
        load_val   = v;
        cyc();
        load_valid = 1'b0;
    endtask

    // Gating schedule for a load of 5: {tick, pause} per edge and expected q/done after it.
    localparam int NG = 13;
    logic [1:0] g_in  [NG] = '{2'b10, 2'b00, 2'b11, 2'b11, 2'b01, 2'b11, 2'b10,
                               2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 2'b10};
    int         g_q   [NG] = '{4, 4, 4, 4, 4, 4, 3, 3, 2, 2, 1, 1, 0};
    int         g_dn  [NG] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    initial begin
        reset_n    = 1'b1;
        load_valid = 1'b0;
        load_val   = '0;
        tick       = 1'b0;
        pause      = 1'b0;
        abort      = 1'b0;
        #2 reset_n = 1'b0;
        cyc();
        cyc();
        chk_out("reset", 0, 0, 0, 1);
        reset_n = 1'b1;
        cyc();

        // Async reset in the middle of a count, checked between edges.
        do_load(10'd500);
        chk_out("load500", 500, 1, 0, 0);
        tick = 1'b1;
        cyc();
        chk("run499.q", int'(q), 499);
        #3 reset_n = 1'b0;
        #1;
        chk_out("async_reset", 0, 0, 0, 1);
        tick = 1'b0;
        cyc();
        reset_n = 1'b1;
        cyc();

        // Clamp, IDLE ignores tick, abort from RUN.
        do_load(10'd1000);
        chk_out("clamp1000", 999, 1, 0, 0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk_out("clamp_abort", 999, 0, 0, 1);
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk_out("idle_tick", 999, 0, 0, 1);
        do_load(10'd1023);
        chk_out("clamp1023", 999, 1, 0, 0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;

        // Zero load.
        do_load(10'd0);
        chk_out("zero_load", 0, 0, 1, 1);
        cyc();
        chk_out("zero_after", 0, 0, 0, 1);

        // Abort priority over tick.
        do_load(10'd10);
        tick = 1'b1;
        for (int i = 9; i >= 6; i--) begin
            cyc();
            chk("abort_run.q", int'(q), i);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        tick  = 1'b0;
        chk_out("abort6", 6, 0, 0, 1);
        cyc();
        chk("abort_nodone", int'(done), 0);
        do_load(10'd2);
        chk_out("reload2", 2, 1, 0, 0);
        abort = 1'b1;
        cyc();
        abort = 1'b0;

`ifndef COUNTDOWN_1K_AUTORELOAD_EN
        // One-shot: 3,2,1,0.
        do_load(10'd3);
        chk_out("os3", 3, 1, 0, 0);
        tick = 1'b1;
        cyc();
        chk_out("os2", 2, 1, 0, 0);
        cyc();
        chk_out("os1", 1, 1, 0, 0);
        cyc();
        chk_out("os0", 0, 0, 1, 1);
        tick = 1'b0;
        cyc();
        chk_out("os_end", 0, 0, 0, 1);

        // Back-to-back: load on the edge where done is high; load offered in RUN is held off.
        do_load(10'd2);
        tick = 1'b1;
        cyc();
        chk("b2b.q1", int'(q), 1);
        load_valid = 1'b1;
        load_val   = 10'd1;
        cyc();
        chk_out("b2b_term", 0, 0, 1, 1);
        cyc();
        load_valid = 1'b0;
        chk_out("b2b_load", 1, 1, 0, 0);
        cyc();
        chk_out("b2b_term2", 0, 0, 1, 1);
        tick = 1'b0;
        cyc();
        chk("b2b_done_drop", int'(done), 0);

        // Tick / pause gating.
        do_load(10'd5);
        for (int i = 0; i < NG; i++) begin
            tick  = g_in[i][1];
            pause = g_in[i][0];
            cyc();
            chk($sformatf("gate%0d.q", i),    int'(q),    g_q[i]);
            chk($sformatf("gate%0d.done", i), int'(done), g_dn[i]);
        end
        tick  = 1'b0;
        pause = 1'b0;
        chk("gate_busy", int'(busy), 0);
`else
        // Autoreload period of 4.
        do_load(10'd4);
        tick = 1'b1;
        for (int p = 0; p < 3; p++) begin
            for (int k = 3; k >= 1; k--) begin
                cyc();
                chk_out($sformatf("ar%0d_%0d", p, k), k, 1, 0, 0);
            end
            cyc();
            chk_out($sformatf("ar%0d_wrap", p), 4, 1, 1, 0);
        end
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        tick  = 1'b0;
        chk_out("ar_abort", 4, 0, 0, 1);
        cyc();
        chk("ar_stopped", int'(done), 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
